// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and controller state encoding for the 1RW SRAM controller.
package sram_ctrl_pkg;

   localparam int SRAM_ADDR_W = 10;
   localparam int SRAM_DATA_W = 44;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ctrl_state_e;

endpackage : sram_ctrl_pkg

// File: rtl/sram1rw_1024x44_ctrl_resp_fifo2.sv
// Two-entry response buffer that holds read data the consumer has not yet taken.
module resp_fifo2 #(
   parameter int DATA_W = 44
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              empty,
   output logic [1:0]        count,
   output logic [DATA_W-1:0] head
);

   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; count/pointers already mark every entry invalid.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign empty = (count_q == 2'd0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule : resp_fifo2

// File: rtl/sram1rw_1024x44_ctrl.sv
// Controller for a 1RW SRAM macro: zero-scrub after reset, then a valid/ready
// request port with in-order, credit-limited read responses.
module sram1rw_1024x44_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W,
   parameter int DEPTH  = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              init_done,
   output logic [ADDR_W-1:0] sram_a,
   output logic              sram_csb,
   output logic              sram_web,
   output logic              sram_oeb,
   output logic [DATA_W-1:0] sram_i,
   input  logic [DATA_W-1:0] sram_o
);

   localparam logic [ADDR_W-1:0] SCRUB_LAST = ADDR_W'(DEPTH - 1);

   ctrl_state_e       state_q, state_d;
   logic [ADDR_W-1:0] scrub_q, scrub_d;
   logic              rd_pending_q, rd_pending_d;

   logic              fire;
   logic              fifo_push, fifo_pop, fifo_empty;
   logic [1:0]        fifo_count;
   logic [DATA_W-1:0] fifo_head;

   always_comb begin
      state_d      = state_q;
      scrub_d      = scrub_q;
      rd_pending_d = 1'b0;
      req_ready    = 1'b0;
      fire         = 1'b0;
      sram_csb     = 1'b1;
      sram_web     = 1'b1;
      sram_oeb     = 1'b1;
      sram_a       = req_addr;
      sram_i       = req_wdata;

      case (state_q)
         ST_INIT: begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
            sram_a   = scrub_q;
            sram_i   = '0;
            scrub_d  = scrub_q + 1'b1;
            if (scrub_q == SCRUB_LAST) begin
               state_d = ST_RUN;
               scrub_d = '0;
            end
         end
         ST_RUN: begin
            // One credit per buffered or in-flight read keeps the FIFO from overflowing.
            req_ready = (({1'b0, fifo_count} + {2'b00, rd_pending_q}) <= 3'd1);
            fire      = req_valid & req_ready;
            if (fire) begin
               sram_csb = 1'b0;
               sram_web = ~req_write;
               sram_oeb = req_write;
            end
            rd_pending_d = fire & ~req_write;
         end
         default: state_d = ST_INIT;
      endcase

      // The macro must stay deselected while reset is held, even though INIT drives it.
      if (reset) begin
         sram_csb = 1'b1;
         sram_web = 1'b1;
         sram_oeb = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_INIT;
         scrub_q      <= '0;
         rd_pending_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         scrub_q      <= scrub_d;
         rd_pending_q <= rd_pending_d;
      end
   end

   // Read data bypasses the FIFO only when nothing older is queued and it is taken now.
   assign fifo_push  = rd_pending_q & ~(fifo_empty & resp_ready);
   assign fifo_pop   = resp_ready & ~fifo_empty;
   assign resp_valid = ~fifo_empty | rd_pending_q;
   assign resp_rdata = fifo_empty ? sram_o : fifo_head;
   assign init_done  = (state_q == ST_RUN);

   resp_fifo2 #(
      .DATA_W(DATA_W)
   ) u_resp_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (fifo_push),
      .push_data(sram_o),
      .pop      (fifo_pop),
      .empty    (fifo_empty),
      .count    (fifo_count),
      .head     (fifo_head)
   );

endmodule : sram1rw_1024x44_ctrl

// File: tb/tb_sram1rw_1024x44_ctrl.sv
// Self-checking bench: behavioural SRAM macro, reference memory and a response scoreboard.
module tb_sram1rw_1024x44_ctrl;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 44;
   localparam int DEPTH  = 1024;

   logic              clock;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              init_done;
   logic [ADDR_W-1:0] sram_a;
   logic              sram_csb;
   logic              sram_web;
   logic              sram_oeb;
   logic [DATA_W-1:0] sram_i;
   logic [DATA_W-1:0] sram_o;

   sram1rw_1024x44_ctrl #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .init_done (init_done),
      .sram_a    (sram_a),
      .sram_csb  (sram_csb),
      .sram_web  (sram_web),
      .sram_oeb  (sram_oeb),
      .sram_i    (sram_i),
      .sram_o    (sram_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural macro: synchronous write, registered read data one cycle after a read.
   logic [DATA_W-1:0] macro_mem [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) macro_mem[i] = 44'({$urandom(), $urandom()}) | 44'h1;
      sram_o = 44'({$urandom(), $urandom()});
   end
   always @(posedge clock) begin
      if (!sram_csb) begin
         if (!sram_web) macro_mem[sram_a] <= sram_i;
         else if (!sram_oeb) sram_o <= macro_mem[sram_a];
      end
   end

   // Reference model and scoreboard.
   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] exp_q [$];
   int n_checks = 0;
   int n_errors = 0;
   int n_reads  = 0;
   int n_resp   = 0;
   int n_stray  = 0;
   logic rdy_s, rv_s;

   typedef struct {
      logic              v;
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              rr;
      logic              exp_rdy;
      logic              exp_rv;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic rr,
                               input logic exp_rdy, input logic exp_rv);
      vec_t t;
      t.v = v; t.w = w; t.a = a; t.d = d; t.rr = rr; t.exp_rdy = exp_rdy; t.exp_rv = exp_rv;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_ref();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      exp_q.delete();
   endtask

   // One clock cycle: drive at the falling edge, sample 1 time unit later, update the model.
   task automatic cycle(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic rr,
                        output logic rdy, output logic rv);
      logic [DATA_W-1:0] exp;
      @(negedge clock);
      req_valid  = v;
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      resp_ready = rr;
      #1;
      rdy = req_ready;
      rv  = resp_valid;
      if (resp_valid && resp_ready) begin
         n_resp++;
         if (exp_q.size() == 0) n_stray++;
         else begin
            exp = exp_q.pop_front();
            check("resp_data", 64'(resp_rdata), 64'(exp));
         end
      end
      if (req_valid && req_ready) begin
         if (req_write) ref_mem[req_addr] = req_wdata;
         else begin
            exp_q.push_back(ref_mem[req_addr]);
            n_reads++;
         end
      end
   endtask

   task automatic idle(input logic rr);
      cycle(1'b0, 1'b0, '0, '0, rr, rdy_s, rv_s);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1'b1);
      idle(1'b1);
      check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic scrub_check(input string tag);
      int bad = 0;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         if (init_done !== 1'b0 || req_ready !== 1'b0 || sram_csb !== 1'b0 ||
             sram_web !== 1'b0 || sram_oeb !== 1'b1 || sram_a !== ADDR_W'(i) ||
             sram_i !== '0) bad++;
         @(negedge clock);
      end
      #1;
      check({tag, "_scrub_bad_cycles"}, 64'(bad), 64'd0);
      check({tag, "_init_done"}, 64'(init_done), 64'd1);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
   endtask

   task automatic reset_pins_check(input string tag);
      check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      check({tag, "_init_done"}, 64'(init_done), 64'd0);
      check({tag, "_csb_web_oeb"}, 64'({sram_csb, sram_web, sram_oeb}), 64'd7);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_resp, base_reads, drops;
      logic [ADDR_W-1:0] ra;

      vecs[0]  = mk(1'b1, 1'b1, 10'd5, 44'hABC_DEAD_BEEF, 1'b1, 1'b1, 1'b0);
      vecs[1]  = mk(1'b1, 1'b0, 10'd5, 44'h0,             1'b1, 1'b1, 1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 10'd0, 44'h0,             1'b1, 1'b1, 1'b1);
      vecs[3]  = mk(1'b0, 1'b0, 10'd0, 44'h0,             1'b1, 1'b1, 1'b0);
      vecs[4]  = mk(1'b1, 1'b1, 10'd7, 44'h777,           1'b1, 1'b1, 1'b0);
      vecs[5]  = mk(1'b1, 1'b1, 10'd8, 44'h888,           1'b1, 1'b1, 1'b0);
      vecs[6]  = mk(1'b1, 1'b0, 10'd5, 44'h0,             1'b0, 1'b1, 1'b0);
      vecs[7]  = mk(1'b1, 1'b0, 10'd7, 44'h0,             1'b0, 1'b1, 1'b1);
      vecs[8]  = mk(1'b1, 1'b0, 10'd8, 44'h0,             1'b0, 1'b0, 1'b1);
      vecs[9]  = mk(1'b1, 1'b0, 10'd8, 44'h0,             1'b0, 1'b0, 1'b1);
      vecs[10] = mk(1'b1, 1'b0, 10'd8, 44'h0,             1'b1, 1'b0, 1'b1);
      vecs[11] = mk(1'b1, 1'b0, 10'd8, 44'h0,             1'b1, 1'b1, 1'b1);
      vecs[12] = mk(1'b0, 1'b0, 10'd0, 44'h0,             1'b1, 1'b1, 1'b1);
      vecs[13] = mk(1'b0, 1'b0, 10'd0, 44'h0,             1'b1, 1'b1, 1'b0);

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;
      clear_ref();
      repeat (3) @(negedge clock);
      #1;
      reset_pins_check("por");

      scrub_check("init1");

      // Scrubbed memory reads back as zero at both ends and the middle.
      cycle(1'b1, 1'b0, 10'd0,    '0, 1'b1, rdy_s, rv_s);
      cycle(1'b1, 1'b0, 10'd1023, '0, 1'b1, rdy_s, rv_s);
      cycle(1'b1, 1'b0, 10'd512,  '0, 1'b1, rdy_s, rv_s);
      drain("scrub_reads");

      // Directed vectors: write-then-read latency and the two-credit backpressure case.
      for (int i = 0; i < 14; i++) begin
         cycle(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rr, rdy_s, rv_s);
         check($sformatf("vec%0d_req_ready", i), 64'(rdy_s), 64'(vecs[i].exp_rdy));
         check($sformatf("vec%0d_resp_valid", i), 64'(rv_s), 64'(vecs[i].exp_rv));
      end
      check("vec_queue_empty", 64'(exp_q.size()), 64'd0);

      // Back-to-back reads sustain one per cycle.
      for (int i = 0; i < 16; i++)
         cycle(1'b1, 1'b1, ADDR_W'(i), DATA_W'(i + 1), 1'b1, rdy_s, rv_s);
      idle(1'b1);
      base_resp = n_resp;
      drops = 0;
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 1'b0, ADDR_W'(i), '0, 1'b1, rdy_s, rv_s);
         if (rdy_s !== 1'b1) drops++;
      end
      idle(1'b1);
      check("b2b_ready_drops", 64'(drops), 64'd0);
      check("b2b_resp_count", 64'(n_resp - base_resp), 64'd16);
      drain("b2b");

      // Random traffic against the reference model.
      base_resp  = n_resp;
      base_reads = n_reads;
      for (int i = 0; i < 10000; i++) begin
         ra = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 15))
                                          : ADDR_W'($urandom_range(0, DEPTH - 1));
         cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra,
               44'({$urandom(), $urandom()}), ($urandom_range(0, 3) != 0), rdy_s, rv_s);
      end
      drain("rand");
      check("rand_resp_per_read", 64'(n_resp - base_resp), 64'(n_reads - base_reads));

      // Reset with two responses buffered: everything in flight is discarded.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 10'd3, '0, 1'b0, rdy_s, rv_s);
      check("pre_reset_buffered", 64'(exp_q.size()), 64'd2);
      check("pre_reset_resp_valid", 64'(resp_valid), 64'd1);
      @(negedge clock);
      reset     = 1'b1;
      req_valid = 1'b0;
      #1;
      reset_pins_check("midrst");
      clear_ref();
      repeat (2) @(negedge clock);
      #1;
      reset_pins_check("midrst_hold");

      scrub_check("init2");
      for (int i = 0; i < 8; i++) idle(1'b1);
      cycle(1'b1, 1'b0, 10'd3, '0, 1'b1, rdy_s, rv_s);
      cycle(1'b1, 1'b0, 10'd7, '0, 1'b1, rdy_s, rv_s);
      drain("post_reset");
      check("stray_responses", 64'(n_stray), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_sram1rw_1024x44_ctrl
